// File: rtl/lamp_pwm_driver.sv
// Lamp PWM driver: turns the controller's on/off request into a PWM drive
// whose duty ramps one LSB at a time toward a captured target brightness.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OFF       | lamp dark, nivel = 0, waiting for saida
// RAMP_UP   | stepping nivel toward alvo (either direction)
// ON        | nivel held at alvo, brilho_max ignored
// RAMP_DOWN | stepping nivel toward 0; saida re-request restarts RAMP_UP
module lamp_pwm_driver #(
    parameter int PWM_BITS    = 8,
    parameter int RAMP_STEP_T = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                saida,
    input  logic [PWM_BITS-1:0] brilho_max,
    output logic                lampada,
    output logic [PWM_BITS-1:0] nivel,
    output logic                acesa,
    output logic                rampa_ativa
);

    localparam int STEP_W = (RAMP_STEP_T > 1) ? $clog2(RAMP_STEP_T) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(RAMP_STEP_T - 1);
    // PWM counter stops one short of all-ones so that nivel = all-ones is a
    // true 100% duty.
    localparam logic [PWM_BITS-1:0] PWM_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PWM_BITS-1:0] alvo;
    logic [PWM_BITS-1:0] alvo_next;
    logic [PWM_BITS-1:0] nivel_next;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic                tick;

    assign tick = (step_cnt == STEP_LAST);

    // Next-state, target capture and brightness stepping.
    always_comb begin
        state_next = state;
        alvo_next  = alvo;
        nivel_next = nivel;
        case (state)
            OFF: begin
                if (saida) begin
                    state_next = RAMP_UP;
                    alvo_next  = brilho_max;
                end
            end
            RAMP_UP: begin
                // A reversal wins over a pending tick so nivel never jumps.
                if (!saida) begin
                    state_next = RAMP_DOWN;
                end else if (nivel == alvo) begin
                    state_next = ON;
                end else if (tick) begin
                    if (nivel < alvo) nivel_next = nivel + 1'b1;
                    else              nivel_next = nivel - 1'b1;
                end
            end
            ON: begin
                if (!saida) state_next = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (saida) begin
                    state_next = RAMP_UP;
                    alvo_next  = brilho_max;
                end else if (nivel == '0) begin
                    state_next = OFF;
                end else if (tick) begin
                    nivel_next = nivel - 1'b1;
                end
            end
            default: state_next = OFF;
        endcase
    end

    // State, target, level and status registers; status follows next-state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= OFF;
            alvo        <= '0;
            nivel       <= '0;
            acesa       <= 1'b0;
            rampa_ativa <= 1'b0;
        end else begin
            state       <= state_next;
            alvo        <= alvo_next;
            nivel       <= nivel_next;
            acesa       <= (state_next != OFF);
            rampa_ativa <= (state_next == RAMP_UP) || (state_next == RAMP_DOWN);
        end
    end

    // Step prescaler: restarts on every state entry so k steps take k*RAMP_STEP_T cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (state_next != state) begin
            step_cnt <= '0;
        end else if (tick) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    // Free-running PWM counter, independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Registered PWM compare drives the lamp stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lampada <= 1'b0;
        end else begin
            lampada <= (pwm_cnt < nivel);
        end
    end

endmodule

// File: tb/tb_lamp_pwm_driver.sv
// Directed bench for lamp_pwm_driver with hand-computed expectations.
module tb_lamp_pwm_driver;

    logic       clk;
    logic       rst;
    logic       saida;
    logic [7:0] brilho_max;
    logic       lampada;
    logic [7:0] nivel;
    logic       acesa;
    logic       rampa_ativa;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    lamp_pwm_driver #(.PWM_BITS(8), .RAMP_STEP_T(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .saida       (saida),
        .brilho_max  (brilho_max),
        .lampada     (lampada),
        .nivel       (nivel),
        .acesa       (acesa),
        .rampa_ativa (rampa_ativa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int highs;
        int found;

        rst = 1'b1; saida = 1'b0; brilho_max = 8'd0;
        cyc(2);
        check("rst_lampada", int'(lampada), 0);
        check("rst_nivel", int'(nivel), 0);
        check("rst_acesa", int'(acesa), 0);
        check("rst_rampa", int'(rampa_ativa), 0);
        rst = 1'b0;
        cyc(3);
        check("idle_acesa", int'(acesa), 0);
        check("idle_lampada", int'(lampada), 0);

        // Full soft-start to 255
        brilho_max = 8'd255; saida = 1'b1;
        cyc(1);
        check("up_rampa_entry", int'(rampa_ativa), 1);
        check("up_acesa_entry", int'(acesa), 1);
        check("up_nivel_entry", int'(nivel), 0);
        cyc(19);
        check("up_nivel_19", int'(nivel), 0);
        cyc(1);
        check("up_nivel_20", int'(nivel), 1);
        cyc(5079);
        check("up_nivel_5099", int'(nivel), 254);
        cyc(1);
        check("up_nivel_5100", int'(nivel), 255);
        check("up_rampa_5100", int'(rampa_ativa), 1);
        cyc(1);
        check("full_on_rampa", int'(rampa_ativa), 0);
        check("full_on_acesa", int'(acesa), 1);
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            if (lampada) highs++;
        end
        check("full_on_always_high", highs, 300);

        // Fade from 255, re-request at 150 with lower target 50
        saida = 1'b0;
        cyc(1);
        check("fade_rampa", int'(rampa_ativa), 1);
        check("fade_nivel_entry", int'(nivel), 255);
        cyc(2100);
        check("fade_nivel_150", int'(nivel), 150);
        brilho_max = 8'd50; saida = 1'b1;
        cyc(1);
        check("rereq_rampa", int'(rampa_ativa), 1);
        check("rereq_nivel", int'(nivel), 150);
        cyc(20);
        check("rereq_nivel_149", int'(nivel), 149);
        cyc(1980);
        check("rereq_nivel_50", int'(nivel), 50);
        check("rereq_still_ramp", int'(rampa_ativa), 1);
        cyc(1);
        check("rereq_on_rampa", int'(rampa_ativa), 0);
        check("rereq_on_acesa", int'(acesa), 1);

        // Fade 50 -> 0 -> OFF
        saida = 1'b0;
        cyc(1001);
        check("fade50_nivel_0", int'(nivel), 0);
        check("fade50_acesa", int'(acesa), 1);
        cyc(1);
        check("fade50_off", int'(acesa), 0);

        // Partial target 64
        brilho_max = 8'd64; saida = 1'b1;
        cyc(1281);
        check("p64_nivel", int'(nivel), 64);
        check("p64_rampa", int'(rampa_ativa), 1);
        cyc(1);
        check("p64_on_rampa", int'(rampa_ativa), 0);
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            cyc(1);
            if (lampada) highs++;
        end
        check("p64_duty", highs, 64);
        brilho_max = 8'd200;
        cyc(50);
        check("p64_hold_nivel", int'(nivel), 64);
        check("p64_hold_rampa", int'(rampa_ativa), 0);

        // Fade to OFF, then ramp toward 200 and reverse at 100 on a tick cycle
        saida = 1'b0;
        cyc(1282);
        check("p64_off_acesa", int'(acesa), 0);
        check("p64_off_nivel", int'(nivel), 0);
        saida = 1'b1;
        cyc(2020);
        check("rev_nivel_100", int'(nivel), 100);
        saida = 1'b0;
        cyc(1);
        check("rev_nivel_nojump", int'(nivel), 100);
        check("rev_rampa", int'(rampa_ativa), 1);
        cyc(19);
        check("rev_nivel_19", int'(nivel), 100);
        cyc(1);
        check("rev_nivel_99", int'(nivel), 99);
        cyc(1980);
        check("rev_nivel_0", int'(nivel), 0);
        check("rev_acesa_pre", int'(acesa), 1);
        cyc(1);
        check("rev_off", int'(acesa), 0);

        // Zero target
        brilho_max = 8'd0; saida = 1'b1;
        cyc(1);
        check("zero_rampa", int'(rampa_ativa), 1);
        cyc(1);
        check("zero_on_rampa", int'(rampa_ativa), 0);
        check("zero_on_acesa", int'(acesa), 1);
        check("zero_on_nivel", int'(nivel), 0);
        check("zero_on_lampada", int'(lampada), 0);
        saida = 1'b0;
        cyc(1);
        check("zero_down_rampa", int'(rampa_ativa), 1);
        cyc(1);
        check("zero_off_acesa", int'(acesa), 0);
        check("zero_off_rampa", int'(rampa_ativa), 0);

        // Reset while ON at 128, taken while the lamp is lit
        brilho_max = 8'd128; saida = 1'b1;
        cyc(2562);
        check("r128_nivel", int'(nivel), 128);
        check("r128_rampa", int'(rampa_ativa), 0);
        found = 0;
        for (int i = 0; i < 300; i++) begin
            if (lampada) begin
                found = 1;
                break;
            end
            cyc(1);
        end
        check("r128_lit", found, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_lampada", int'(lampada), 0);
        check("async_rst_nivel", int'(nivel), 0);
        check("async_rst_acesa", int'(acesa), 0);
        check("async_rst_rampa", int'(rampa_ativa), 0);
        cyc(1);
        rst = 1'b0; saida = 1'b0;
        cyc(3);
        check("post_rst_acesa", int'(acesa), 0);
        check("post_rst_nivel", int'(nivel), 0);
        check("post_rst_lampada", int'(lampada), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lamp_pwm_driver.md
Name: lamp_pwm_driver

Overview:
Power-stage driver that consumes the controller's `saida` lamp-on request and produces a PWM lamp drive with soft-start and soft-fade ramps. It sits downstream of the controller in `top`, on the same `clk`. It converts the controller's binary on/off decision into a brightness level that ramps to a programmable target, and exposes status back to the system.

Parameters:
- PWM_BITS, 8: width of brightness level, target and PWM counter.
- RAMP_STEP_T, 20: clk cycles per one-LSB brightness step during ramps (must be >= 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- saida  in  1  lamp-on request from controller; same clock domain, level-sensitive, no synchronizer.
- brilho_max  in  PWM_BITS  target brightness, sampled only at ramp-up start.
- lampada  out  1  registered PWM drive to lamp stage.
- nivel  out  PWM_BITS  current brightness level.
- acesa  out  1  high whenever state != OFF.
- rampa_ativa  out  1  high in RAMP_UP or RAMP_DOWN.

Behaviour:
- Reset (async, rst=1): state=OFF, nivel=0, alvo=0, step_cnt=0, pwm_cnt=0, lampada=0, acesa=0, rampa_ativa=0. Reset mid-ramp aborts immediately; lamp dark on the same edge.
- PWM:
  - pwm_cnt free-runs 0..2^PWM_BITS-2 and then wraps; the period is 2^PWM_BITS-1 cycles (255 at default).
  - lampada is registered as (pwm_cnt < nivel), giving 1-cycle latency.
  - nivel=0 means always low; nivel=2^PWM_BITS-1 means always high.
  - pwm_cnt is not reset by state changes.
- Step prescaler:
  - step_cnt clears on every state entry and otherwise counts 0..RAMP_STEP_T-1.
  - A tick fires when step_cnt==RAMP_STEP_T-1, and nivel updates on the following edge.
  - Consequence: k steps take k*RAMP_STEP_T cycles after state entry.
- FSM states: OFF, RAMP_UP, ON, RAMP_DOWN.
- OFF:
  - saida=1 -> RAMP_UP; alvo <= brilho_max captured on the same edge.
- RAMP_UP:
  - If saida=0 -> RAMP_DOWN; nivel is retained with no jump. Reversal takes priority over a simultaneous tick, so no step occurs that cycle.
  - Else, if nivel==alvo (checked every cycle, before tick) -> ON. Hence alvo=0 reaches ON 1 cycle after entry, with nivel still 0.
  - Else, on tick, nivel moves one LSB toward alvo (+1 if below, -1 if above).
- ON:
  - nivel is held; brilho_max changes are ignored.
  - saida=0 -> RAMP_DOWN.
- RAMP_DOWN:
  - If saida=1 -> RAMP_UP; alvo re-captured from brilho_max. If the new alvo < nivel, RAMP_UP walks down to it.
  - Else, if nivel==0 -> OFF.
  - Else, on tick, nivel <= nivel-1.
- Arithmetic: nivel never wraps. It increments only when < alvo and decrements only when > 0 (or > alvo). All counters are unsigned.
- Status: acesa and rampa_ativa are registered from next-state, so they are valid in the same cycle as state.

Test Plan:
1. Reset mid-ON: assert rst with nivel=128 -> lampada, nivel, acesa all 0 immediately; after release, state=OFF.
2. Full soft-start (brilho_max=255, RAMP_STEP_T=20):
   - saida 0->1 -> rampa_ativa=1 next cycle.
   - nivel=1 at +20 cycles, 255 at +5100 cycles, then ON with lampada constantly high.
3. Partial target (brilho_max=64):
   - Ramp completes at nivel=64.
   - Over one 255-cycle PWM period, lampada is high for exactly 64 cycles.
   - Changing brilho_max to 200 while ON leaves nivel=64.
4. Reversal mid-ramp:
   - Drop saida while nivel=100 in RAMP_UP -> RAMP_DOWN with nivel=100 (no jump).
   - nivel=99 after 20 cycles; reaches 0 and OFF after 2000 cycles.
5. Re-request during fade:
   - In RAMP_DOWN at nivel=150, set brilho_max=50 and saida=1 -> RAMP_UP.
   - nivel walks down to 50, then ON.
6. Zero target (brilho_max=0, saida=1):
   - RAMP_UP for 1 cycle, then ON with nivel=0, lampada=0, acesa=1.
   - saida=0 -> RAMP_DOWN -> OFF next cycle.
